axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- Burst-capable memory slave on the bus side of the two-master arbiter (instruction fetch and data memory stages).
- Consumes the arbiter's merged read channel and write channel, and returns data and responses.
- Backs the CPU's whole physical memory window with a 64-bit word array.
- Read and write paths are independent FSMs, so one read burst and one write burst can proceed concurrently.

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 64: data width. Fixed at 64; strobe is DATA_W/8.
- BASE_ADDR, 32'h8000_0000: first byte address served.
- DEPTH_WORDS, 65536: number of 64-bit words in the array.
- INIT_FILE, "": optional hex image loaded at elaboration. Empty means the array contents are unspecified at start.

Ports:
- clk input 1: clock. All state changes on its rising edge.
- rst input 1: reset. Asynchronous assertion, active-low.
- araddr input 32: read burst start byte address.
- arvalid input 1: read address valid.
- arburst input 2: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- arlen input 8: read beats minus 1.
- arsize input 3: bytes per beat is 2^arsize.
- arready output 1: read address accepted.
- rdata output 64: read beat data.
- rresp output 2: read beat response.
- rvalid output 1: read beat valid.
- rlast output 1: final read beat.
- rready input 1: read master ready.
- awaddr input 32: write burst start byte address.
- awvalid input 1: write address valid.
- awburst input 2: write burst type, same encoding as arburst.
- awlen input 8: write beats minus 1.
- awready output 1: write address accepted.
- wdata input 64: write beat data.
- wlast input 1: master's final-beat marker.
- wstrb input 8: byte enables.
- wvalid input 1: write beat valid.
- wready output 1: write beat accepted.
- bresp output 2: write response.
- bvalid output 1: write response valid.
- bready input 1: write response ready.

Behaviour:
- Reset values (rst low, asynchronous): arready=1, awready=1, rvalid=0, rlast=0, wready=0, bvalid=0, rdata=0, rresp=0, bresp=0. Both FSMs go to IDLE and all burst counters clear.
- Reset mid-burst: the burst is abandoned with no response. Array contents are preserved.
- Address mapping: word index = (addr - BASE_ADDR) >> 3. addr[2:0] is ignored.
- A beat is in range iff BASE_ADDR <= addr < BASE_ADDR + 8*DEPTH_WORDS.
- Next beat address: INCR is addr+8, modulo 2^32. FIXED keeps the same address.
- Range is checked per beat, so an INCR burst running off the end gets DECERR only on the out-of-range beats.
- Response codes: OKAY 00, SLVERR 10, DECERR 11.
- Read FSM: R_IDLE -> R_DATA.
  - R_IDLE: arready=1. On arvalid&arready, latch addr, len, burst and the error class.
  - Error class: SLVERR if arburst is WRAP or reserved, or if arsize>3. Otherwise decided per beat by range.
  - Next cycle: R_DATA with rvalid=1 and beat 0 presented. arready=0 throughout R_DATA.
  - Beat data is registered into rdata on the edge that presents the beat. Latency from the address handshake to the first rvalid is 1 cycle.
  - rdata, rresp and rlast hold stable while rvalid&!rready.
  - On rvalid&rready: if beat==len, return to R_IDLE (one-cycle arready bubble before the next burst). Otherwise present the next beat on the following cycle, giving full throughput of one beat per cycle.
  - rlast=1 exactly on beat==len.
  - Any beat with an error: rdata=0, no array access.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On awvalid&awready, latch awaddr, awlen, awburst. awready=0 until back in W_IDLE.
  - W_DATA: wready=1. Each wvalid&wready writes bytes i where wstrb[i]=1 to the current word. Error beats write nothing.
  - The burst ends after awlen+1 beats regardless of wlast.
  - wlast mismatch, i.e. wlast asserted with beat!=len, or wlast=0 with beat==len: bresp becomes SLVERR, but in-range data is still written.
  - WRAP or reserved awburst: SLVERR, no writes.
  - bresp is the worst code over all beats, priority DECERR > SLVERR > OKAY.
  - W_RESP: bvalid=1, held until bready. Then return to W_IDLE.
- Concurrent read and write to the same word on the same edge: the read beat captures the pre-write value (read-before-write).
- Reads never block writes and writes never block reads.
- Array is one write port plus one read port, behavioural, synthesised as a register array or inferred RAM.

Decomposition:
- Shared package: RESP_OKAY, RESP_SLVERR, RESP_DECERR, BURST_FIXED, BURST_INCR, BURST_WRAP constants, plus read and write FSM state encodings.
- Sub-module axi_burst_addr_gen: latches the start address, len and burst, advances the address per beat, and outputs beat count, last flag, in-range flag and word index.
- axi_burst_addr_gen is instantiated once per channel.

Test Plan:
- Single read: preload word at 0x8000_0010 = 64'h1122334455667788. Send araddr=0x8000_0010, arlen=0, INCR. Expect rvalid one cycle after the handshake, rdata=64'h1122334455667788, rresp=00, rlast=1.
- INCR read: arlen=3 from 0x8000_0000, with rready low for 2 cycles on beat 1. Expect 4 beats from consecutive words, beat 1 held stable, rlast only on beat 3, arready back high one cycle after the last beat.
- Strobed write then read: awaddr=0x8000_0100, awlen=0, wdata=64'hFFFF_FFFF_FFFF_FFFF, wstrb=8'h0F over an old value of 0. Expect bresp=00 and a readback of 64'h0000_0000_FFFF_FFFF.
- Out of range: araddr=0x7FFF_FFF8, arlen=1. Expect beat 0 rresp=11 with rdata=0, and beat 1 (0x8000_0000) rresp=00 with the word's data.
- Write protocol errors:
  - awlen=2 with wlast on beat 1: expect 3 beats consumed, bresp=10, data written.
  - awburst=WRAP: expect bresp=10 and memory unchanged.
- Reset mid-burst: pull rst low during beat 2 of an arlen=7 read. Expect rvalid=0 and arready=1 immediately with no clock edge, and a fresh read returning correct data after release.

Source files
------------

// File: rtl/axi_sram_slave_pkg.sv
// rtl/axi_sram_slave_pkg.sv - shared constants and FSM encodings for the SRAM slave
// Purpose: response and burst codes, read/write FSM state types, response merge helper.
package axi_sram_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  // The numeric order of the codes matches their severity (DECERR > SLVERR > OKAY).
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// rtl/axi_sram_slave_if.sv - read/write burst bus between the arbiter and the SRAM slave
// Purpose: groups the AR/R/AW/W/B channel signals.
// Modports: slave (the memory), master (the arbiter side / testbench).
interface axi_sram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic [1:0]          arburst;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rlast;
  logic                rready;

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic [1:0]          awburst;
  logic [7:0]          awlen;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic                wlast;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport slave (
    input  araddr, arvalid, arburst, arlen, arsize,
    output arready,
    output rdata, rresp, rvalid, rlast,
    input  rready,
    input  awaddr, awvalid, awburst, awlen,
    output awready,
    input  wdata, wlast, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

  modport master (
    output araddr, arvalid, arburst, arlen, arsize,
    input  arready,
    input  rdata, rresp, rvalid, rlast,
    output rready,
    output awaddr, awvalid, awburst, awlen,
    input  awready,
    output wdata, wlast, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

endinterface

// File: rtl/axi_sram_slave_addr_gen.sv
// rtl/axi_sram_slave_addr_gen.sv - per-channel burst address generator
// Purpose: latches start address/len/burst, steps the address per beat and decodes it.
// Ports: clk, rst (async active-low); load/start_* capture a burst; advance steps one beat;
//        beat, last, in_range, word_idx describe the selected beat.
// LOOKAHEAD=1 decodes the beat being loaded/advanced to this cycle (for a registered read
// that must be fetched on the same edge); LOOKAHEAD=0 decodes the currently held beat.
module axi_burst_addr_gen
  import axi_sram_slave_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                DEPTH_WORDS = 65536,
  parameter int                IDX_W       = $clog2(DEPTH_WORDS),
  parameter bit                LOOKAHEAD   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [7:0]        start_len,
  input  logic [1:0]        start_burst,
  input  logic              advance,
  output logic [7:0]        beat,
  output logic              last,
  output logic              in_range,
  output logic [IDX_W-1:0]  word_idx
);

  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH_WORDS) << 3;

  logic [ADDR_W-1:0] addr_q, addr_d, addr_step;
  logic [7:0]        len_q, len_d;
  logic [1:0]        burst_q, burst_d;
  logic [7:0]        beat_q, beat_d;

  always_comb begin
    case (burst_q)
      BURST_FIXED: addr_step = addr_q;
      BURST_INCR:  addr_step = addr_q + ADDR_W'(8);
      default:     addr_step = addr_q;  // error bursts never touch the array
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    len_d   = len_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    if (load) begin
      addr_d  = start_addr;
      len_d   = start_len;
      burst_d = start_burst;
      beat_d  = '0;
    end else if (advance) begin
      addr_d = addr_step;
      beat_d = beat_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      beat_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
    end
  end

  logic [ADDR_W-1:0] sel_addr, offset;
  logic [7:0]        sel_len;

  assign sel_addr = LOOKAHEAD ? addr_d : addr_q;
  assign sel_len  = LOOKAHEAD ? len_d  : len_q;
  assign beat     = LOOKAHEAD ? beat_d : beat_q;
  assign last     = (beat == sel_len);

  // Wrapping subtraction turns the two-sided range test into one unsigned compare.
  assign offset   = sel_addr - BASE_ADDR;
  assign in_range = ({1'b0, offset} < SPAN);
  assign word_idx = IDX_W'(offset >> 3);

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - burst-capable 64-bit SRAM slave with independent read and write FSMs
// Purpose: serves the physical memory window from a word array; one read burst and one
//          write burst may run concurrently.
// Ports: clk, rst (async active-low), s (slave side of axi_sram_slave_if).
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                DEPTH_WORDS = 65536,
  parameter                    INIT_FILE   = ""
) (
  input  logic             clk,
  input  logic             rst,
  axi_sram_slave_if.slave  s
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // ---------------- read channel ----------------
  rd_state_e         rd_state_q, rd_state_d;
  logic              ar_hs, r_hs, r_adv, r_done, ar_slverr;
  logic              rd_slverr_q, rd_slverr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;
  logic              rd_last, rd_in_range;
  logic [IDX_W-1:0]  rd_idx;
  logic [7:0]        rd_beat_unused;

  assign ar_hs     = s.arvalid && (rd_state_q == R_IDLE);
  assign r_hs      = (rd_state_q == R_DATA) && s.rready;
  assign r_adv     = r_hs && !rlast_q;
  assign r_done    = r_hs && rlast_q;
  assign ar_slverr = (s.arburst >= BURST_WRAP) || (s.arsize > 3'd3);

  axi_burst_addr_gen #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W(IDX_W), .LOOKAHEAD(1'b1)
  ) u_rd_gen (
    .clk(clk), .rst(rst),
    .load(ar_hs), .start_addr(s.araddr), .start_len(s.arlen), .start_burst(s.arburst),
    .advance(r_adv),
    .beat(rd_beat_unused), .last(rd_last), .in_range(rd_in_range), .word_idx(rd_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_q  <= R_IDLE;
      rd_slverr_q <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      rlast_q     <= 1'b0;
    end else begin
      rd_state_q  <= rd_state_d;
      rd_slverr_q <= rd_slverr_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      rlast_q     <= rlast_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:  if (ar_hs)  rd_state_d = R_DATA;
      R_DATA:  if (r_done) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    s.arready = (rd_state_q == R_IDLE);
    s.rvalid  = (rd_state_q == R_DATA);
  end

  // The beat is fetched on the edge that presents it, so the array read sees the value
  // before any write landing on the same edge.
  always_comb begin
    rd_slverr_d = rd_slverr_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rlast_d     = rlast_q;
    if (ar_hs) rd_slverr_d = ar_slverr;
    if (ar_hs || r_adv) begin
      rlast_d = rd_last;
      if (rd_slverr_d) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end else if (!rd_in_range) begin
        rdata_d = '0;
        rresp_d = RESP_DECERR;
      end else begin
        rdata_d = mem[rd_idx];
        rresp_d = RESP_OKAY;
      end
    end else if (r_done) begin
      rlast_d = 1'b0;
    end
  end

  assign s.rdata = rdata_q;
  assign s.rresp = rresp_q;
  assign s.rlast = rlast_q;

  // ---------------- write channel ----------------
  wr_state_e         wr_state_q, wr_state_d;
  logic              aw_hs, w_hs, mem_we;
  logic              wr_slverr_q, wr_slverr_d;
  logic [1:0]        bresp_q, bresp_d, beat_resp;
  logic              wr_last, wr_in_range;
  logic [IDX_W-1:0]  wr_idx;
  logic [7:0]        wr_beat_unused;

  assign aw_hs = s.awvalid && (wr_state_q == W_IDLE);
  assign w_hs  = s.wvalid && (wr_state_q == W_DATA);

  axi_burst_addr_gen #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W(IDX_W), .LOOKAHEAD(1'b0)
  ) u_wr_gen (
    .clk(clk), .rst(rst),
    .load(aw_hs), .start_addr(s.awaddr), .start_len(s.awlen), .start_burst(s.awburst),
    .advance(w_hs),
    .beat(wr_beat_unused), .last(wr_last), .in_range(wr_in_range), .word_idx(wr_idx)
  );

  // A wlast disagreement flags SLVERR but the in-range beat is still written.
  always_comb begin
    if (wr_slverr_q)            beat_resp = RESP_SLVERR;
    else if (!wr_in_range)      beat_resp = RESP_DECERR;
    else if (s.wlast != wr_last) beat_resp = RESP_SLVERR;
    else                        beat_resp = RESP_OKAY;
  end

  assign mem_we = w_hs && !wr_slverr_q && wr_in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state_q  <= W_IDLE;
      wr_slverr_q <= 1'b0;
      bresp_q     <= RESP_OKAY;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_slverr_q <= wr_slverr_d;
      bresp_q     <= bresp_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      W_IDLE:  if (aw_hs)           wr_state_d = W_DATA;
      W_DATA:  if (w_hs && wr_last) wr_state_d = W_RESP;
      W_RESP:  if (s.bready)        wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    s.awready = (wr_state_q == W_IDLE);
    s.wready  = (wr_state_q == W_DATA);
    s.bvalid  = (wr_state_q == W_RESP);
  end

  always_comb begin
    wr_slverr_d = wr_slverr_q;
    bresp_d     = bresp_q;
    if (aw_hs) begin
      wr_slverr_d = (s.awburst >= BURST_WRAP);
      bresp_d     = (s.awburst >= BURST_WRAP) ? RESP_SLVERR : RESP_OKAY;
    end else if (w_hs) begin
      bresp_d = resp_worst(bresp_q, beat_resp);
    end
  end

  assign s.bresp = bresp_q;

  // Array has no reset so its contents survive a mid-burst reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (s.wstrb[i]) mem[wr_idx][8*i +: 8] <= s.wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - self-checking bench for axi_sram_slave
module tb_axi_sram_slave;
  import axi_sram_slave_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_sram_slave_if bus ();

  axi_sram_slave #(
    .ADDR_W(32), .DATA_W(64), .BASE_ADDR(32'h8000_0000),
    .DEPTH_WORDS(65536), .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .s(bus)
  );

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] W0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] W2 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] W3 = 64'h0F1E_2D3C_4B5A_6978;
  localparam logic [63:0] WL = 64'hDEAD_BEEF_CAFE_F00D;

  logic [63:0] rd_d [16];
  logic [1:0]  rd_r [16];
  logic        rd_l [16];
  logic [63:0] wd [8];
  logic [7:0]  ws [8];
  logic        wl [8];

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [1:0]  r0;
    logic [63:0] d0;
    logic [1:0]  r1;
    logic [63:0] d1;
  } rvec_t;

  rvec_t tv [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size, input int stall_beat);
    int n;
    bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arsize = size;
    bus.arvalid = 1'b1; bus.rready = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin tick(); n++; end
    if (!bus.arready) chk({tag, " arready_timeout"}, 0, 1);
    tick();
    bus.arvalid = 1'b0;
    chk({tag, " rvalid_latency"}, bus.rvalid, 1);
    chk({tag, " arready_busy"}, bus.arready, 0);
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!bus.rvalid && n < 20) begin tick(); n++; end
      if (!bus.rvalid) chk({tag, " rvalid_timeout"}, 0, 1);
      rd_d[b] = bus.rdata; rd_r[b] = bus.rresp; rd_l[b] = bus.rlast;
      if (b == stall_beat) begin
        bus.rready = 1'b0;
        repeat (2) begin
          tick();
          chk({tag, " stall_rvalid"}, bus.rvalid, 1);
          chk({tag, " stall_rdata"}, bus.rdata, rd_d[b]);
          chk({tag, " stall_rlast"}, bus.rlast, rd_l[b]);
        end
        bus.rready = 1'b1;
      end
      tick();
    end
    chk({tag, " end_rvalid"}, bus.rvalid, 0);
    chk({tag, " end_arready"}, bus.arready, 1);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int nbeats, input logic [1:0] exp_bresp);
    int n;
    bus.awaddr = addr; bus.awlen = len; bus.awburst = burst;
    bus.awvalid = 1'b1; bus.bready = 1'b1;
    n = 0;
    while (!bus.awready && n < 20) begin tick(); n++; end
    if (!bus.awready) chk({tag, " awready_timeout"}, 0, 1);
    tick();
    bus.awvalid = 1'b0;
    chk({tag, " wready_open"}, bus.wready, 1);
    chk({tag, " awready_busy"}, bus.awready, 0);
    for (int b = 0; b < nbeats; b++) begin
      bus.wdata = wd[b]; bus.wstrb = ws[b]; bus.wlast = wl[b]; bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < 20) begin tick(); n++; end
      if (!bus.wready) chk({tag, " wready_timeout"}, 0, 1);
      tick();
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    chk({tag, " bvalid"}, bus.bvalid, 1);
    chk({tag, " bresp"}, bus.bresp, exp_bresp);
    chk({tag, " wready_closed"}, bus.wready, 0);
    tick();
    chk({tag, " bvalid_drop"}, bus.bvalid, 0);
    chk({tag, " awready_back"}, bus.awready, 1);
  endtask

  task automatic set_beat(input int b, input logic [63:0] d, input logic [7:0] s, input logic l);
    wd[b] = d; ws[b] = s; wl[b] = l;
  endtask

  initial begin
    bus.araddr = '0; bus.arvalid = 0; bus.arburst = '0; bus.arlen = '0; bus.arsize = '0;
    bus.rready = 0; bus.awaddr = '0; bus.awvalid = 0; bus.awburst = '0; bus.awlen = '0;
    bus.wdata = '0; bus.wlast = 0; bus.wstrb = '0; bus.wvalid = 0; bus.bready = 0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst arready", bus.arready, 1);
    chk("rst awready", bus.awready, 1);
    chk("rst rvalid", bus.rvalid, 0);
    chk("rst rlast", bus.rlast, 0);
    chk("rst wready", bus.wready, 0);
    chk("rst bvalid", bus.bvalid, 0);
    chk("rst rdata", bus.rdata, 0);
    chk("rst rresp", bus.rresp, 0);
    chk("rst bresp", bus.bresp, 0);
    rst = 1'b1;
    tick();

    // preload
    set_beat(0, W0, 8'hFF, 0); set_beat(1, W1, 8'hFF, 0);
    set_beat(2, W2, 8'hFF, 0); set_beat(3, W3, 8'hFF, 1);
    do_write("pre_incr", 32'h8000_0000, 8'd3, BURST_INCR, 4, RESP_OKAY);
    set_beat(0, WL, 8'hFF, 1);
    do_write("pre_top", 32'h8007_FFF8, 8'd0, BURST_INCR, 1, RESP_OKAY);

    // table-driven reads
    tv[0] = '{32'h8000_0010, 8'd0, BURST_INCR,  3'd3, RESP_OKAY,   W2,  RESP_OKAY,   64'd0};
    tv[1] = '{32'h7FFF_FFF8, 8'd1, BURST_INCR,  3'd3, RESP_DECERR, 0,   RESP_OKAY,   W0};
    tv[2] = '{32'h8000_0008, 8'd0, BURST_WRAP,  3'd3, RESP_SLVERR, 0,   RESP_OKAY,   64'd0};
    tv[3] = '{32'h8000_0008, 8'd0, BURST_INCR,  3'd4, RESP_SLVERR, 0,   RESP_OKAY,   64'd0};
    tv[4] = '{32'h8000_0008, 8'd1, BURST_FIXED, 3'd3, RESP_OKAY,   W1,  RESP_OKAY,   W1};
    tv[5] = '{32'h8007_FFF8, 8'd1, BURST_INCR,  3'd3, RESP_OKAY,   WL,  RESP_DECERR, 0};
    tv[6] = '{32'h8000_0014, 8'd0, BURST_INCR,  3'd3, RESP_OKAY,   W2,  RESP_OKAY,   64'd0};
    tv[7] = '{32'h8000_0018, 8'd0, BURST_INCR,  3'd2, RESP_OKAY,   W3,  RESP_OKAY,   64'd0};
    for (int i = 0; i < 8; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      do_read(t, tv[i].addr, tv[i].len, tv[i].burst, tv[i].size, -1);
      chk({t, " d0"}, rd_d[0], tv[i].d0);
      chk({t, " r0"}, rd_r[0], tv[i].r0);
      chk({t, " last0"}, rd_l[0], (tv[i].len == 8'd0));
      if (tv[i].len == 8'd1) begin
        chk({t, " d1"}, rd_d[1], tv[i].d1);
        chk({t, " r1"}, rd_r[1], tv[i].r1);
        chk({t, " last1"}, rd_l[1], 1);
      end
    end

    // INCR burst with a 2-cycle stall on beat 1
    do_read("incr4", 32'h8000_0000, 8'd3, BURST_INCR, 3'd3, 1);
    chk("incr4 d0", rd_d[0], W0); chk("incr4 d1", rd_d[1], W1);
    chk("incr4 d2", rd_d[2], W2); chk("incr4 d3", rd_d[3], W3);
    chk("incr4 lasts", {rd_l[0], rd_l[1], rd_l[2], rd_l[3]}, 4'b0001);
    chk("incr4 resps", {rd_r[0], rd_r[1], rd_r[2], rd_r[3]}, 8'h00);

    // strobed write over zero
    set_beat(0, 64'd0, 8'hFF, 1);
    do_write("zero", 32'h8000_0100, 8'd0, BURST_INCR, 1, RESP_OKAY);
    set_beat(0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1);
    do_write("strb", 32'h8000_0100, 8'd0, BURST_INCR, 1, RESP_OKAY);
    do_read("strb_rd", 32'h8000_0100, 8'd0, BURST_INCR, 3'd3, -1);
    chk("strb data", rd_d[0], 64'h0000_0000_FFFF_FFFF);

    // early wlast: all three beats still consumed and written
    set_beat(0, 64'h1111_1111_1111_1111, 8'hFF, 0);
    set_beat(1, 64'h2222_2222_2222_2222, 8'hFF, 1);
    set_beat(2, 64'h3333_3333_3333_3333, 8'hFF, 0);
    do_write("wlast_err", 32'h8000_0200, 8'd2, BURST_INCR, 3, RESP_SLVERR);
    do_read("wlast_rd", 32'h8000_0200, 8'd2, BURST_INCR, 3'd3, -1);
    chk("wlast d0", rd_d[0], 64'h1111_1111_1111_1111);
    chk("wlast d1", rd_d[1], 64'h2222_2222_2222_2222);
    chk("wlast d2", rd_d[2], 64'h3333_3333_3333_3333);

    // WRAP write is rejected without touching memory
    set_beat(0, 64'h9999_9999_9999_9999, 8'hFF, 1);
    do_write("wrap_wr", 32'h8000_0200, 8'd0, BURST_WRAP, 1, RESP_SLVERR);
    do_read("wrap_rd", 32'h8000_0200, 8'd0, BURST_INCR, 3'd3, -1);
    chk("wrap unchanged", rd_d[0], 64'h1111_1111_1111_1111);

    // write running off the top: DECERR, in-range beat written
    set_beat(0, 64'hE0E0_E0E0_E0E0_E0E0, 8'hFF, 0);
    set_beat(1, 64'hE1E1_E1E1_E1E1_E1E1, 8'hFF, 1);
    do_write("top_wr", 32'h8007_FFF8, 8'd1, BURST_INCR, 2, RESP_DECERR);
    do_read("top_rd", 32'h8007_FFF8, 8'd0, BURST_INCR, 3'd3, -1);
    chk("top data", rd_d[0], 64'hE0E0_E0E0_E0E0_E0E0);

    // reset during beat 2 of an 8-beat read
    bus.araddr = 32'h8000_0000; bus.arlen = 8'd7; bus.arburst = BURST_INCR; bus.arsize = 3'd3;
    bus.arvalid = 1'b1; bus.rready = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    tick(); tick();
    chk("mid beat2 rvalid", bus.rvalid, 1);
    chk("mid beat2 rdata", bus.rdata, W2);
    #2 rst = 1'b0;
    #1;
    chk("mid rst rvalid", bus.rvalid, 0);
    chk("mid rst arready", bus.arready, 1);
    chk("mid rst rdata", bus.rdata, 0);
    #2 rst = 1'b1;
    tick();
    do_read("post_rst", 32'h8000_0010, 8'd0, BURST_INCR, 3'd3, -1);
    chk("post_rst data", rd_d[0], W2);
    chk("post_rst resp", rd_r[0], RESP_OKAY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
